rv32_exec_ctrl: RTL and testbench

RV32I decode-and-execute slice: main control decode, immediate generation, ALU operand muxing, ALU, branch resolution and next-PC computation.
It sits between the register file/PC register and data memory in the single-cycle core.
Outputs are registered, so results appear one cycle after the instruction is presented.

---
 rtl/rv32_exec_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_rv32_exec_ctrl.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/rv32_exec_ctrl.sv
// RV32I decode/execute slice: control decode, immediates, ALU, branch resolve, next PC.
// Registered outputs. Optional macro EXEC_ILLEGAL_CHECK_EN enables strict illegal-encoding checks.
module rv32_exec_ctrl #(
  parameter int unsigned XLEN     = 32,
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     cmd,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  output logic [XLEN-1:0] alu_result,
  output logic [XLEN-1:0] dnpc,
  output logic            en_wreg,
  output logic [4:0]      rd,
  output logic            load,
  output logic            store,
  output logic [7:0]      wmask,
  output logic [1:0]      load_sext,
  output logic [XLEN-1:0] store_data,
  output logic            illegal
);

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpReg    = 7'b0110011;

  localparam logic [XLEN-1:0] Four = {{(XLEN-3){1'b0}}, 3'd4};

  typedef enum logic [3:0] {
    AluAdd, AluSub, AluSll, AluSlt, AluSltu, AluXor, AluSrl, AluSra, AluOr, AluAnd
  } alu_op_e;

  function automatic alu_op_e f3_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? AluSub : AluAdd;
      3'b001:  return AluSll;
      3'b010:  return AluSlt;
      3'b011:  return AluSltu;
      3'b100:  return AluXor;
      3'b101:  return alt ? AluSra : AluSrl;
      3'b110:  return AluOr;
      default: return AluAnd;
    endcase
  endfunction

  logic [6:0] opcode;
  logic [2:0] funct3;
  assign opcode = cmd[6:0];
  assign funct3 = cmd[14:12];

  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  assign imm_i = {{20{cmd[31]}}, cmd[31:20]};
  assign imm_s = {{20{cmd[31]}}, cmd[31:25], cmd[11:7]};
  assign imm_b = {{19{cmd[31]}}, cmd[31], cmd[7], cmd[30:25], cmd[11:8], 1'b0};
  assign imm_u = {cmd[31:12], 12'b0};
  assign imm_j = {{11{cmd[31]}}, cmd[31], cmd[19:12], cmd[20], cmd[30:21], 1'b0};

  logic [XLEN-1:0] op_a, op_b;
  alu_op_e         alu_op;
  logic            wreg_dec, load_dec, store_dec, is_branch, is_jal, is_jalr;
  logic [7:0]      wmask_dec;
  logic [1:0]      sext_dec;
  logic            ill_dec;

  logic [7:0] width_mask;
  always_comb begin
    case (funct3[1:0])
      2'b00:   width_mask = 8'h01;
      2'b01:   width_mask = 8'h03;
      default: width_mask = 8'h0F;
    endcase
  end

  always_comb begin
    op_a      = src1;
    op_b      = src2;
    alu_op    = AluAdd;
    wreg_dec  = 1'b0;
    load_dec  = 1'b0;
    store_dec = 1'b0;
    is_branch = 1'b0;
    is_jal    = 1'b0;
    is_jalr   = 1'b0;
    wmask_dec = 8'h00;
    sext_dec  = 2'b00;
    case (opcode)
      OpLui:    begin op_a = '0; op_b = imm_u; wreg_dec = 1'b1; end
      OpAuipc:  begin op_a = pc; op_b = imm_u; wreg_dec = 1'b1; end
      OpJal:    begin op_a = pc; op_b = Four; wreg_dec = 1'b1; is_jal = 1'b1; end
      OpJalr:   begin op_a = pc; op_b = Four; wreg_dec = 1'b1; is_jalr = 1'b1; end
      OpBranch: begin alu_op = AluSub; is_branch = 1'b1; end
      OpLoad: begin
        op_b      = imm_i;
        load_dec  = 1'b1;
        wreg_dec  = 1'b1;
        wmask_dec = width_mask;
        // Word width (and the undefined 11 width) needs no extension.
        sext_dec  = funct3[1] ? 2'b00 : (funct3[2] ? 2'b10 : 2'b01);
      end
      OpStore: begin
        op_b      = imm_s;
        store_dec = 1'b1;
        wmask_dec = width_mask;
      end
      OpImm: begin
        op_b     = imm_i;
        wreg_dec = 1'b1;
        alu_op   = f3_op(funct3, (funct3 == 3'b101) && cmd[30]);
      end
      OpReg: begin
        wreg_dec = 1'b1;
        alu_op   = f3_op(funct3, cmd[30]);
      end
      default: ;
    endcase
  end

`ifdef EXEC_ILLEGAL_CHECK_EN
  always_comb begin
    ill_dec = 1'b0;
    case (opcode)
      OpLui, OpAuipc, OpJal: ill_dec = 1'b0;
      OpJalr:   ill_dec = (funct3 != 3'b000);
      OpBranch: ill_dec = (funct3[2:1] == 2'b01);
      OpLoad:   ill_dec = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
      OpStore:  ill_dec = funct3[2] || (funct3[1:0] == 2'b11);
      OpImm: begin
        if (funct3 == 3'b001) ill_dec = (cmd[31:25] != 7'h00);
        else if (funct3 == 3'b101) ill_dec = (cmd[31:25] != 7'h00) && (cmd[31:25] != 7'h20);
      end
      OpReg: begin
        if (cmd[31:25] == 7'h20) ill_dec = (funct3 != 3'b000) && (funct3 != 3'b101);
        else                     ill_dec = (cmd[31:25] != 7'h00);
      end
      default: ill_dec = 1'b1;
    endcase
  end
`else
  assign ill_dec = 1'b0;
`endif

  // ALU and comparison flags; the 33-bit difference exposes the unsigned borrow.
  logic [XLEN:0]   diff;
  logic            lt_s, lt_u, is_zero, less, taken;
  logic [4:0]      shamt;
  logic [XLEN-1:0] alu_out;

  assign diff    = {1'b0, op_a} - {1'b0, op_b};
  assign lt_u    = diff[XLEN];
  assign lt_s    = (op_a[XLEN-1] != op_b[XLEN-1]) ? op_a[XLEN-1] : diff[XLEN-1];
  assign is_zero = (diff[XLEN-1:0] == '0);
  assign less    = funct3[1] ? lt_u : lt_s;
  assign taken   = funct3[2] ? (less ^ funct3[0]) : (is_zero ^ funct3[0]);
  assign shamt   = op_b[4:0];

  always_comb begin
    alu_out = op_a + op_b;
    case (alu_op)
      AluSub:  alu_out = diff[XLEN-1:0];
      AluSll:  alu_out = op_a << shamt;
      AluSlt:  alu_out = {{(XLEN-1){1'b0}}, lt_s};
      AluSltu: alu_out = {{(XLEN-1){1'b0}}, lt_u};
      AluXor:  alu_out = op_a ^ op_b;
      AluSrl:  alu_out = op_a >> shamt;
      AluSra:  alu_out = $signed(op_a) >>> shamt;
      AluOr:   alu_out = op_a | op_b;
      AluAnd:  alu_out = op_a & op_b;
      default: ;
    endcase
  end

  logic [XLEN-1:0] jalr_sum, dnpc_d;
  assign jalr_sum = src1 + imm_i;

  always_comb begin
    dnpc_d = pc + Four;
    if (!ill_dec) begin
      if (is_jal)                  dnpc_d = pc + imm_j;
      else if (is_jalr)            dnpc_d = jalr_sum & {{(XLEN-1){1'b1}}, 1'b0};
      else if (is_branch && taken) dnpc_d = pc + imm_b;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_result <= '0;
      dnpc       <= RESET_PC;
      en_wreg    <= 1'b0;
      rd         <= 5'd0;
      load       <= 1'b0;
      store      <= 1'b0;
      wmask      <= 8'h00;
      load_sext  <= 2'b00;
      store_data <= '0;
      illegal    <= 1'b0;
    end else begin
      alu_result <= alu_out;
      dnpc       <= dnpc_d;
      en_wreg    <= wreg_dec & ~ill_dec;
      rd         <= cmd[11:7];
      load       <= load_dec & ~ill_dec;
      store      <= store_dec & ~ill_dec;
      wmask      <= ill_dec ? 8'h00 : wmask_dec;
      load_sext  <= ill_dec ? 2'b00 : sext_dec;
      store_data <= src2;
      illegal    <= ill_dec;
    end
  end

endmodule

// File: tb/tb_rv32_exec_ctrl.sv
// Table-driven bench for rv32_exec_ctrl plus reset and illegal-encoding sequences.
module tb_rv32_exec_ctrl;

`ifdef EXEC_ILLEGAL_CHECK_EN
  localparam bit ILL = 1'b1;
`else
  localparam bit ILL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cmd, pc, src1, src2;
  logic [31:0] alu_result, dnpc, store_data;
  logic        en_wreg, load, store, illegal;
  logic [4:0]  rd;
  logic [7:0]  wmask;
  logic [1:0]  load_sext;

  rv32_exec_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .cmd        (cmd),
    .pc         (pc),
    .src1       (src1),
    .src2       (src2),
    .alu_result (alu_result),
    .dnpc       (dnpc),
    .en_wreg    (en_wreg),
    .rd         (rd),
    .load       (load),
    .store      (store),
    .wmask      (wmask),
    .load_sext  (load_sext),
    .store_data (store_data),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] cmd, pc, src1, src2, alu, dnpc;
    logic        chk_alu, wreg, ld, st;
    logic [7:0]  wmask;
    logic [1:0]  sext;
    logic        ill;
  } vec_t;

  vec_t vecs[$];
  int   total  = 0;
  int   passed = 0;

  function automatic vec_t mk(logic [31:0] c, logic [31:0] p, logic [31:0] s1, logic [31:0] s2,
                              logic [31:0] a, logic [31:0] n, logic ca, logic w, logic l,
                              logic s, logic [7:0] m, logic [1:0] x, logic il);
    vec_t v;
    v.cmd = c; v.pc = p; v.src1 = s1; v.src2 = s2; v.alu = a; v.dnpc = n;
    v.chk_alu = ca; v.wreg = w; v.ld = l; v.st = s; v.wmask = m; v.sext = x; v.ill = il;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s #%0d: got %h, expected %h", name, idx, act, exp);
    else passed++;
  endtask

  task automatic apply(input vec_t v, input int idx);
    cmd = v.cmd; pc = v.pc; src1 = v.src1; src2 = v.src2;
    @(posedge clk);
    #1;
    check("dnpc", idx, dnpc, v.dnpc);
    check("ctrl", idx, {en_wreg, load, store, wmask, load_sext, illegal},
          {v.wreg, v.ld, v.st, v.wmask, v.sext, v.ill});
    check("rd_sdata", idx, {rd, store_data}, {v.cmd[11:7], v.src2});
    if (v.chk_alu) check("alu", idx, alu_result, v.alu);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 100000");
    $fatal(1);
  end

  initial begin
    localparam logic [31:0] P = 32'h8000_0000;
    vec_t jv;
    //         cmd           pc            src1          src2          alu           dnpc       ca w l s mask  sext
    vecs.push_back(mk(32'h00500093, P, 32'h0, 32'h0, 32'h5, P+4, 1, 1, 0, 0, 8'h00, 2'b00, 0));
    vecs.push_back(mk(32'h402081B3, P, 32'h3, 32'h5, 32'hFFFFFFFE, P+4, 1, 1, 0, 0, 8'h00, 2'b00, 0));
    vecs.push_back(mk(32'h4020D1B3, P, P, 32'h4, 32'hF8000000, P+4, 1, 1, 0, 0, 8'h00, 2'b00, 0));
    vecs.push_back(mk(32'h00208463, P, 32'h7, 32'h7, 32'h0, P+8, 0, 0, 0, 0, 8'h00, 2'b00, 0));
    vecs.push_back(mk(32'h00208463, P, 32'h7, 32'h8, 32'h0, P+4, 0, 0, 0, 0, 8'h00, 2'b00, 0));
    vecs.push_back(mk(32'h008080E7, 32'h80000010, 32'h80000101, 32'h0, 32'h80000014,
                      32'h80000108, 1, 1, 0, 0, 8'h00, 2'b00, 0));
    vecs.push_back(mk(32'h0040A183, P, 32'h100, 32'h0, 32'h104, P+4, 1, 1, 1, 0, 8'h0F, 2'b00, 0));
    vecs.push_back(mk(32'h00408183, P, 32'h100, 32'h0, 32'h104, P+4, 1, 1, 1, 0, 8'h01, 2'b01, 0));
    vecs.push_back(mk(32'h0040D183, P, 32'h100, 32'h0, 32'h104, P+4, 1, 1, 1, 0, 8'h03, 2'b10, 0));
    vecs.push_back(mk(32'h0020A423, P, 32'h100, 32'hDEADBEEF, 32'h108, P+4, 1, 0, 0, 1, 8'h0F,
                      2'b00, 0));
    vecs.push_back(mk(32'h123452B7, P, 32'h55, 32'h0, 32'h12345000, P+4, 1, 1, 0, 0, 8'h00, 2'b00, 0));
    vecs.push_back(mk(32'h00001317, P, 32'h0, 32'h0, 32'h80001000, P+4, 1, 1, 0, 0, 8'h00, 2'b00, 0));
    vecs.push_back(mk(32'h010000EF, P, 32'h0, 32'h0, P+4, P+16, 1, 1, 0, 0, 8'h00, 2'b00, 0));
    vecs.push_back(mk(32'h0020C463, P, 32'hFFFFFFFF, 32'h1, 32'h0, P+8, 0, 0, 0, 0, 8'h00, 2'b00, 0));
    vecs.push_back(mk(32'h0020E463, P, 32'hFFFFFFFF, 32'h1, 32'h0, P+4, 0, 0, 0, 0, 8'h00, 2'b00, 0));
    vecs.push_back(mk(32'h0020A1B3, P, 32'hFFFFFFFF, 32'h1, 32'h1, P+4, 1, 1, 0, 0, 8'h00, 2'b00, 0));
    vecs.push_back(mk(32'h0020B1B3, P, 32'hFFFFFFFF, 32'h1, 32'h0, P+4, 1, 1, 0, 0, 8'h00, 2'b00, 0));
    vecs.push_back(mk(32'h002091B3, P, 32'h1, 32'h24, 32'h10, P+4, 1, 1, 0, 0, 8'h00, 2'b00, 0));
    vecs.push_back(mk(32'h40000093, P, 32'h5, 32'h0, 32'h405, P+4, 1, 1, 0, 0, 8'h00, 2'b00, 0));
    vecs.push_back(mk(32'h4040D093, P, P, 32'h0, 32'hF8000000, P+4, 1, 1, 0, 0, 8'h00, 2'b00, 0));
    vecs.push_back(mk(32'h002081B3, P, 32'hFFFFFFFF, 32'h1, 32'h0, P+4, 1, 1, 0, 0, 8'h00, 2'b00, 0));
    vecs.push_back(mk(32'h00500093, 32'hFFFFFFFC, 32'h0, 32'h0, 32'h5, 32'h0, 1, 1, 0, 0, 8'h00,
                      2'b00, 0));
    vecs.push_back(mk(32'h0000000B, P, 32'h1, 32'h2, 32'h0, P+4, 0, 0, 0, 0, 8'h00, 2'b00, ILL));
    // funct7=0x01 on OP: plain add without the check, rejected with it.
    vecs.push_back(mk(32'h022081B3, P, 32'h10, 32'h20, 32'h30, P+4, !ILL, !ILL, 0, 0, 8'h00,
                      2'b00, ILL));

    rst = 1'b0; cmd = 32'h00500093; pc = P; src1 = 32'h1; src2 = 32'h2;
    repeat (2) @(posedge clk);
    #1;
    check("reset_dnpc", 0, dnpc, 32'h80000000);
    check("reset_data", 0, {alu_result, store_data}, 64'h0);
    check("reset_ctrl", 0, {en_wreg, rd, load, store, wmask, load_sext, illegal}, 19'h0);

    rst = 1'b1;
    cmd = 32'h00500093; pc = P; src1 = 32'h0; src2 = 32'h0;
    #1;
    check("latency_hold", 0, {alu_result, en_wreg}, 33'h0);

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i + 1);

    // Asynchronous reset in the middle of a jalr stream.
    jv = vecs[5];
    apply(jv, 100);
    #2 rst = 1'b0;
    #1;
    check("async_rst_dnpc", 101, dnpc, 32'h80000000);
    check("async_rst_ctrl", 101, {alu_result, en_wreg, rd}, 38'h0);
    @(posedge clk);
    #1;
    check("rst_held", 102, {dnpc, alu_result}, {32'h80000000, 32'h0});
    rst = 1'b1;
    apply(jv, 103);

    cmd = 32'hFFFFFFFF; pc = P; src1 = 32'h1; src2 = 32'h2;
    @(posedge clk);
    #1;
    check("all_ones_ctrl", 104, {illegal, en_wreg, load, store}, {ILL, 3'b000});
    check("all_ones_dnpc", 104, dnpc, P + 4);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
